crossbar_ingress_queue: RTL

- Per-input ingress buffer that sits directly upstream of one input port of crossbar_switch.
- Accepts packets (dest + data word) from a source over a valid/ready handshake.
- Stores them in a FIFO and presents the head packet to the crossbar as req/dest/data.
- Pops the head on grant, and flags head-of-line starvation when the crossbar withholds grant too long.
- One instance is used per crossbar input.

---
 rtl/crossbar_ingress_queue_if.sv | 28 ++
 rtl/crossbar_ingress_queue.sv | 77 +++++++
 2 files changed

// File: rtl/crossbar_ingress_queue_if.sv
// Handshake bundle between a packet source, the ingress queue and one crossbar input.
// The slave modport is the queue's view; the master modport drives source data and grant.
interface crossbar_ingress_queue_if #(
    parameter int DW    = 32,
    parameter int DESTW = 2,
    parameter int CW    = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [DESTW-1:0] in_dest;
    logic [DW-1:0]    in_data;
    logic             req;
    logic [DESTW-1:0] dest;
    logic [DW-1:0]    data_out;
    logic             grant;
    logic [CW-1:0]    count;
    logic             starve;

    modport slave (
        input  in_valid, in_dest, in_data, grant,
        output in_ready, req, dest, data_out, count, starve
    );

    modport master (
        output in_valid, in_dest, in_data, grant,
        input  in_ready, req, dest, data_out, count, starve
    );
endinterface

// File: rtl/crossbar_ingress_queue.sv
// Per-input FIFO in front of one crossbar port: show-ahead head packet, pop on grant,
// and a saturating head-of-line starvation counter.
module crossbar_ingress_queue #(
    parameter int DEPTH        = 4,
    parameter int DW           = 32,
    parameter int DESTW        = 2,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    crossbar_ingress_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = 8;

    // Small show-ahead array: the head must be visible combinationally in the cycle
    // after it is written, so the read is asynchronous and maps to LUT RAM.
    logic [DESTW+DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [SW-1:0] starve_cnt_reg;

    logic                req_int;
    logic                ready_int;
    logic                push;
    logic                pop;
    logic [DESTW+DW-1:0] head;

    assign ready_int = (count_reg != CW'(DEPTH));
    assign req_int   = (count_reg != '0);
    assign push      = bus.in_valid && ready_int;
    assign pop       = req_int && bus.grant;
    assign head      = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {bus.in_dest, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            starve_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // Waiting time belongs to the current head only, so any pop restarts it.
            if (pop || !req_int) begin
                starve_cnt_reg <= '0;
            end else if (starve_cnt_reg != SW'(STARVE_LIMIT)) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.in_ready = ready_int;
    assign bus.req      = req_int;
    assign bus.dest     = req_int ? head[DESTW+DW-1:DW] : '0;
    assign bus.data_out = req_int ? head[DW-1:0] : '0;
    assign bus.count    = count_reg;
    assign bus.starve   = (starve_cnt_reg == SW'(STARVE_LIMIT));
endmodule
